activation_pair_fetcher: RTL and testbench

Read-side master for activation_stack during the backward pass. On a start command for L layers it walks stack addresses L-1 down to 0. For each address it issues one pair-read request, captures the lower (addr) and higher (addr+1) activation vectors independently, and presents them as one registered pair with layer index and last flag. It sits between activation_stack's read ports and the backpropagation error/gradient datapath.

---
 rtl/bp_pkg.sv | 21 ++
 rtl/pair_capture_reg.sv | 33 +++
 rtl/activation_pair_fetcher.sv | 145 ++++++++++++++
 tb/tb_activation_pair_fetcher.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared backward-pass definitions: vector width derivation, fetcher state
// encoding and layer-counter sizing helper.
package bp_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_OUT  = 2'd3
    } fetch_state_t;

    function automatic int stack_width(input int neuron_num, input int activation_width);
        return neuron_num * activation_width;
    endfunction

    // Bits needed for a counter holding 0..layer_max.
    function automatic int layer_width(input int layer_max);
        return $clog2(layer_max + 1);
    endfunction

endpackage

// File: rtl/pair_capture_reg.sv
// One valid/ready capture slot: accepts a single beat while enabled and
// holds it, with a captured flag, until cleared for the next request.
module pair_capture_reg #(
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] data,
    output logic             captured,
    output logic             fire
);

    assign in_ready = enable && !captured;
    assign fire     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            data     <= '0;
            captured <= 1'b0;
        end else if (clear) begin
            captured <= 1'b0;
        end else if (fire) begin
            data     <= in_data;
            captured <= 1'b1;
        end
    end

endmodule

// File: rtl/activation_pair_fetcher.sv
// Backward-pass read master: walks activation_stack from layer L-1 down to 0,
// fetching the (addr, addr+1) vector pair per layer and presenting it registered.
module activation_pair_fetcher
    import bp_pkg::*;
#(
    parameter int NEURON_NUM       = 6,
    parameter int ACTIVATION_WIDTH = 8,
    parameter int STACK_ADDR_WIDTH = 10,
    parameter int LAYER_MAX        = 3,
    parameter int LAYER_WIDTH      = 4,
    localparam int STACK_WIDTH     = stack_width(NEURON_NUM, ACTIVATION_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LAYER_WIDTH-1:0]      start_layers,
    input  logic                        start_valid,
    output logic                        start_ready,
    output logic [STACK_ADDR_WIDTH-1:0] stack_addr,
    output logic                        stack_addr_valid,
    input  logic                        stack_addr_ready,
    input  logic [STACK_WIDTH-1:0]      stack_lower,
    input  logic                        stack_lower_valid,
    output logic                        stack_lower_ready,
    input  logic [STACK_WIDTH-1:0]      stack_higher,
    input  logic                        stack_higher_valid,
    output logic                        stack_higher_ready,
    output logic [STACK_WIDTH-1:0]      pair_lower,
    output logic [STACK_WIDTH-1:0]      pair_higher,
    output logic [LAYER_WIDTH-1:0]      pair_layer,
    output logic                        pair_last,
    output logic                        pair_valid,
    input  logic                        pair_ready,
    output logic                        busy,
    output logic                        err
);

    if (LAYER_WIDTH < layer_width(LAYER_MAX)) begin : g_bad_layer_width
        $error("LAYER_WIDTH too narrow for LAYER_MAX");
    end

    fetch_state_t           state, state_next;
    logic [LAYER_WIDTH-1:0] layer, layer_next;
    logic                   err_next;
    logic                   start_legal;
    logic                   capture_clear;
    logic                   capture_en;
    logic                   lower_captured, higher_captured;
    logic                   lower_fire, higher_fire;

    assign start_legal = (start_layers != '0) && (start_layers <= LAYER_WIDTH'(LAYER_MAX));

    always_comb begin
        state_next       = state;
        layer_next       = layer;
        err_next         = 1'b0;
        start_ready      = 1'b0;
        stack_addr_valid = 1'b0;
        capture_clear    = 1'b0;
        capture_en       = 1'b0;
        pair_valid       = 1'b0;
        unique case (state)
            FETCH_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    if (start_legal) begin
                        layer_next = start_layers - LAYER_WIDTH'(1);
                        state_next = FETCH_REQ;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            FETCH_REQ: begin
                stack_addr_valid = 1'b1;
                if (stack_addr_ready) begin
                    capture_clear = 1'b1;
                    state_next    = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                capture_en = 1'b1;
                // Count a capture landing this cycle so the pair is valid the cycle after it.
                if ((lower_captured || lower_fire) && (higher_captured || higher_fire)) begin
                    state_next = FETCH_OUT;
                end
            end
            FETCH_OUT: begin
                pair_valid = 1'b1;
                if (pair_ready) begin
                    if (layer == '0) begin
                        state_next = FETCH_IDLE;
                    end else begin
                        layer_next = layer - LAYER_WIDTH'(1);
                        state_next = FETCH_REQ;
                    end
                end
            end
            default: state_next = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH_IDLE;
            layer <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            layer <= layer_next;
            err   <= err_next;
        end
    end

    pair_capture_reg #(.WIDTH(STACK_WIDTH)) u_lower (
        .clk      (clk),
        .rst      (rst),
        .clear    (capture_clear),
        .enable   (capture_en),
        .in_data  (stack_lower),
        .in_valid (stack_lower_valid),
        .in_ready (stack_lower_ready),
        .data     (pair_lower),
        .captured (lower_captured),
        .fire     (lower_fire)
    );

    pair_capture_reg #(.WIDTH(STACK_WIDTH)) u_higher (
        .clk      (clk),
        .rst      (rst),
        .clear    (capture_clear),
        .enable   (capture_en),
        .in_data  (stack_higher),
        .in_valid (stack_higher_valid),
        .in_ready (stack_higher_ready),
        .data     (pair_higher),
        .captured (higher_captured),
        .fire     (higher_fire)
    );

    assign stack_addr = STACK_ADDR_WIDTH'(layer);
    assign pair_layer = layer;
    assign pair_last  = (layer == '0);
    assign busy       = (state != FETCH_IDLE);

endmodule

// File: tb/tb_activation_pair_fetcher.sv
// Bench for activation_pair_fetcher with a randomized stack responder and a
// list-based model of the expected descending pair sequence.
module tb_activation_pair_fetcher;

    localparam int NN  = 6;
    localparam int AW  = 8;
    localparam int SAW = 10;
    localparam int LM  = 3;
    localparam int LW  = 4;
    localparam int SW  = NN * AW;

    logic          clk;
    logic          rst;
    logic [LW-1:0] start_layers;
    logic          start_valid;
    logic          start_ready;
    logic [SAW-1:0] stack_addr;
    logic          stack_addr_valid;
    logic          stack_addr_ready;
    logic [SW-1:0] stack_lower;
    logic          stack_lower_valid;
    logic          stack_lower_ready;
    logic [SW-1:0] stack_higher;
    logic          stack_higher_valid;
    logic          stack_higher_ready;
    logic [SW-1:0] pair_lower;
    logic [SW-1:0] pair_higher;
    logic [LW-1:0] pair_layer;
    logic          pair_last;
    logic          pair_valid;
    logic          pair_ready;
    logic          busy;
    logic          err;

    activation_pair_fetcher #(
        .NEURON_NUM(NN), .ACTIVATION_WIDTH(AW), .STACK_ADDR_WIDTH(SAW),
        .LAYER_MAX(LM), .LAYER_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .start_layers(start_layers), .start_valid(start_valid), .start_ready(start_ready),
        .stack_addr(stack_addr), .stack_addr_valid(stack_addr_valid), .stack_addr_ready(stack_addr_ready),
        .stack_lower(stack_lower), .stack_lower_valid(stack_lower_valid), .stack_lower_ready(stack_lower_ready),
        .stack_higher(stack_higher), .stack_higher_valid(stack_higher_valid), .stack_higher_ready(stack_higher_ready),
        .pair_lower(pair_lower), .pair_higher(pair_higher), .pair_layer(pair_layer),
        .pair_last(pair_last), .pair_valid(pair_valid), .pair_ready(pair_ready),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] lo;
        logic [SW-1:0] hi;
        logic [LW-1:0] layer;
        logic          last;
    } pair_t;

    int checks = 0;
    int passed = 0;

    logic [SW-1:0] mem [0:LM];
    pair_t obs_q [$];
    int    rise_diff [$];

    int cyc = 0;
    int cfg_lo_dly = -1;
    int cfg_hi_dly = -1;
    bit cfg_rand_addr_rdy = 0;
    bit cfg_stray = 0;
    int pr_mode = 0;
    bit pr_manual = 0;

    int req_count = 0;
    int err_count = 0;
    int hold_bad = 0;
    int stab_bad = 0;
    int last_gap = 0;
    int pfire_cyc = 0;
    int lo_cap_cyc = 0;

    function automatic logic [SW-1:0] mem_at(input int a);
        if (a >= 0 && a <= LM) return mem[a];
        return '0;
    endfunction

    // Reference: pass of L layers yields pairs for k = L-1 .. 0 in order.
    function automatic pair_t exp_pair(input int L, input int i);
        pair_t p;
        int k;
        k       = L - 1 - i;
        p.lo    = mem[k];
        p.hi    = mem[k + 1];
        p.layer = LW'(k);
        p.last  = (k == 0);
        return p;
    endfunction

    initial forever @(posedge clk) cyc++;

    // Stack responder and passive monitor.
    initial begin : responder
        bit a_fire, lo_fire, hi_fire, p_fire;
        bit active, lo_got, hi_got;
        bit prev_av, prev_pv, prev_av_stall, prev_pv_stall;
        int resp_addr, lo_wait, hi_wait;
        logic [SAW-1:0] prev_addr;
        pair_t snap, cur;
        active = 0; lo_got = 0; hi_got = 0;
        prev_av = 0; prev_pv = 0; prev_av_stall = 0; prev_pv_stall = 0;
        resp_addr = 0; lo_wait = 0; hi_wait = 0; prev_addr = '0;
        stack_addr_ready = 1'b1;
        stack_lower = '0; stack_lower_valid = 1'b0;
        stack_higher = '0; stack_higher_valid = 1'b0;
        pair_ready = 1'b1;
        forever begin
            @(negedge clk);
            a_fire  = stack_addr_valid && stack_addr_ready;
            lo_fire = stack_lower_valid && stack_lower_ready;
            hi_fire = stack_higher_valid && stack_higher_ready;
            p_fire  = pair_valid && pair_ready;
            cur.lo = pair_lower; cur.hi = pair_higher; cur.layer = pair_layer; cur.last = pair_last;
            if (!rst) begin
                if (err) err_count++;
                if (stack_addr_valid && !prev_av) last_gap = cyc - pfire_cyc;
                if (prev_av_stall && (!stack_addr_valid || stack_addr != prev_addr)) stab_bad++;
                if (prev_pv_stall && (!pair_valid || {cur.lo, cur.hi, cur.layer, cur.last} != {snap.lo, snap.hi, snap.layer, snap.last}))
                    stab_bad++;
                if (pair_valid && !prev_pv) rise_diff.push_back(cyc - lo_cap_cyc);
                if (active && hi_got && !lo_got && stack_higher_ready) hold_bad++;
                if (active && lo_got && !hi_got && stack_lower_ready) hold_bad++;
                if (a_fire) req_count++;
                if (lo_fire) lo_cap_cyc = cyc;
                if (p_fire) begin
                    obs_q.push_back(cur);
                    pfire_cyc = cyc;
                end
            end
            prev_av       = stack_addr_valid;
            prev_pv       = pair_valid;
            prev_av_stall = stack_addr_valid && !stack_addr_ready;
            prev_pv_stall = pair_valid && !pair_ready;
            prev_addr     = stack_addr;
            snap          = cur;

            @(posedge clk);
            #2;
            if (rst) begin
                active = 0;
            end else begin
                if (a_fire) begin
                    active    = 1;
                    resp_addr = int'(prev_addr);
                    lo_got    = 0;
                    hi_got    = 0;
                    lo_wait   = (cfg_lo_dly < 0) ? int'($urandom_range(0, 3)) : cfg_lo_dly;
                    hi_wait   = (cfg_hi_dly < 0) ? int'($urandom_range(0, 3)) : cfg_hi_dly;
                end
                if (lo_fire) lo_got = 1;
                if (hi_fire) hi_got = 1;
                if (active && lo_got && hi_got) active = 0;
            end
            if (active && !lo_got) begin
                if (lo_wait == 0) begin
                    stack_lower_valid = 1'b1;
                    stack_lower       = mem_at(resp_addr);
                end else begin
                    lo_wait--;
                    stack_lower_valid = 1'b0;
                end
            end else begin
                stack_lower_valid = cfg_stray ? 1'($urandom_range(0, 1)) : 1'b0;
                stack_lower       = SW'({$urandom(), $urandom()});
            end
            if (active && !hi_got) begin
                if (hi_wait == 0) begin
                    stack_higher_valid = 1'b1;
                    stack_higher       = mem_at(resp_addr + 1);
                end else begin
                    hi_wait--;
                    stack_higher_valid = 1'b0;
                end
            end else begin
                stack_higher_valid = cfg_stray ? 1'($urandom_range(0, 1)) : 1'b0;
                stack_higher       = SW'({$urandom(), $urandom()});
            end
            stack_addr_ready = cfg_rand_addr_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (pr_mode == 0)      pair_ready = 1'b1;
            else if (pr_mode == 1) pair_ready = 1'($urandom_range(0, 1));
            else                   pair_ready = pr_manual;
        end
    end

    task automatic start_pass(input logic [LW-1:0] L);
        @(posedge clk); #1;
        start_layers = L;
        start_valid  = 1'b1;
        @(posedge clk); #1;
        start_valid  = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (!busy) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (start_ready !== 1'b1) $display("FAIL reset_start_ready: got %b want 1", start_ready); else passed++;
        checks++; if ({busy, err, stack_addr_valid, stack_lower_ready, stack_higher_ready, pair_valid} !== 6'b0)
            $display("FAIL reset_ctrl: got %b want 000000", {busy, err, stack_addr_valid, stack_lower_ready, stack_higher_ready, pair_valid});
        else passed++;
        checks++; if ({pair_lower, pair_higher, pair_layer} !== '0)
            $display("FAIL reset_pair_regs: got %h want 0", {pair_lower, pair_higher, pair_layer});
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        pair_t e;
        for (int k = 0; k <= LM; k++) mem[k] = {NN{8'(k + 1)}};
        cfg_lo_dly = 0; cfg_hi_dly = 0; pr_mode = 0;
        obs_q.delete();
        start_pass(4'd3);
        wait_idle(ok);
        checks++; if (!ok) $display("FAIL basic_timeout: busy=%b want 0", busy); else passed++;
        checks++; if (obs_q.size() !== 3) $display("FAIL basic_count: got %0d want 3", obs_q.size()); else passed++;
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            e = exp_pair(3, i);
            checks++;
            if ({obs_q[i].lo, obs_q[i].hi, obs_q[i].layer, obs_q[i].last} !== {e.lo, e.hi, e.layer, e.last})
                $display("FAIL basic_pair%0d: got %h/%h/%0d/%b want %h/%h/%0d/%b", i,
                         obs_q[i].lo, obs_q[i].hi, obs_q[i].layer, obs_q[i].last, e.lo, e.hi, e.layer, e.last);
            else passed++;
        end
        checks++; if (busy !== 1'b0 || start_ready !== 1'b1) $display("FAIL basic_idle: busy=%b start_ready=%b want 0/1", busy, start_ready); else passed++;
    endtask

    task automatic test_order();
        bit ok;
        pair_t e;
        int hb;
        for (int k = 0; k <= LM; k++) mem[k] = SW'({$urandom(), $urandom()});
        cfg_lo_dly = 3; cfg_hi_dly = 0; pr_mode = 0;
        hb = hold_bad;
        obs_q.delete();
        rise_diff.delete();
        start_pass(4'd3);
        wait_idle(ok);
        checks++; if (!ok) $display("FAIL order_timeout: busy=%b want 0", busy); else passed++;
        checks++; if (rise_diff.size() < 1 || rise_diff[0] !== 1)
            $display("FAIL order_latency: got %0d want 1", (rise_diff.size() > 0) ? rise_diff[0] : -1);
        else passed++;
        checks++; if (hold_bad - hb !== 0) $display("FAIL order_ready_after_capture: got %0d want 0", hold_bad - hb); else passed++;
        checks++; if (obs_q.size() !== 3) $display("FAIL order_count: got %0d want 3", obs_q.size()); else passed++;
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            e = exp_pair(3, i);
            checks++;
            if ({obs_q[i].lo, obs_q[i].hi, obs_q[i].layer, obs_q[i].last} !== {e.lo, e.hi, e.layer, e.last})
                $display("FAIL order_pair%0d: got %h/%h/%0d want %h/%h/%0d", i,
                         obs_q[i].lo, obs_q[i].hi, obs_q[i].layer, e.lo, e.hi, e.layer);
            else passed++;
        end
        cfg_lo_dly = -1; cfg_hi_dly = -1;
    endtask

    task automatic test_backpressure();
        bit ok, seen;
        int unstable;
        pair_t e;
        logic [2*SW+LW:0] held;
        for (int k = 0; k <= LM; k++) mem[k] = SW'({$urandom(), $urandom()});
        cfg_lo_dly = 0; cfg_hi_dly = 0;
        pr_manual = 0; pr_mode = 2;
        obs_q.delete();
        start_pass(4'd2);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (pair_valid) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        checks++; if (!seen) $display("FAIL bp_first_valid: pair_valid=%b want 1", pair_valid); else passed++;
        held = {pair_lower, pair_higher, pair_layer, pair_last};
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!pair_valid || stack_addr_valid || {pair_lower, pair_higher, pair_layer, pair_last} !== held) unstable++;
        end
        checks++; if (unstable !== 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", unstable); else passed++;
        pr_manual = 1;
        wait_idle(ok);
        checks++; if (!ok) $display("FAIL bp_timeout: busy=%b want 0", busy); else passed++;
        checks++; if (last_gap !== 1) $display("FAIL bp_next_req_gap: got %0d want 1", last_gap); else passed++;
        checks++; if (obs_q.size() !== 2) $display("FAIL bp_count: got %0d want 2", obs_q.size()); else passed++;
        for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
            e = exp_pair(2, i);
            checks++;
            if ({obs_q[i].lo, obs_q[i].hi, obs_q[i].layer, obs_q[i].last} !== {e.lo, e.hi, e.layer, e.last})
                $display("FAIL bp_pair%0d: got %h/%h/%0d want %h/%h/%0d", i,
                         obs_q[i].lo, obs_q[i].hi, obs_q[i].layer, e.lo, e.hi, e.layer);
            else passed++;
        end
        pr_mode = 0; cfg_lo_dly = -1; cfg_hi_dly = -1;
    endtask

    task automatic test_illegal();
        int e0, r0, sr_bad;
        logic [LW-1:0] bad_vals [2];
        bad_vals[0] = '0;
        bad_vals[1] = LW'(LM + 1);
        for (int v = 0; v < 2; v++) begin
            e0 = err_count; r0 = req_count; sr_bad = 0;
            start_pass(bad_vals[v]);
            checks++; if (err !== 1'b1) $display("FAIL illegal%0d_err_pulse: got %b want 1", v, err); else passed++;
            for (int i = 0; i < 4; i++) begin
                if (start_ready !== 1'b1 || busy !== 1'b0) sr_bad++;
                @(posedge clk); #1;
            end
            checks++; if (err_count - e0 !== 1) $display("FAIL illegal%0d_err_cycles: got %0d want 1", v, err_count - e0); else passed++;
            checks++; if (req_count - r0 !== 0 || sr_bad !== 0)
                $display("FAIL illegal%0d_no_req: got req=%0d sr_bad=%0d want 0/0", v, req_count - r0, sr_bad);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        for (int k = 0; k <= LM; k++) mem[k] = SW'({$urandom(), $urandom()});
        cfg_lo_dly = 6; cfg_hi_dly = 6; pr_mode = 0;
        start_pass(4'd3);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (stack_lower_ready) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        checks++; if (!seen) $display("FAIL rstmid_wait_state: lower_ready=%b want 1", stack_lower_ready); else passed++;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({pair_valid, stack_addr_valid, stack_lower_ready, stack_higher_ready, busy, start_ready} !== 6'b000001)
            $display("FAIL rstmid_outputs: got %b want 000001",
                     {pair_valid, stack_addr_valid, stack_lower_ready, stack_higher_ready, busy, start_ready});
        else passed++;
        rst = 1'b0;
        cfg_lo_dly = -1; cfg_hi_dly = -1;
        obs_q.delete();
        start_pass(4'd1);
        wait_idle(ok);
        checks++; if (!ok || obs_q.size() !== 1) $display("FAIL rstmid_count: got %0d want 1", obs_q.size()); else passed++;
        if (obs_q.size() > 0) begin
            checks++;
            if ({obs_q[0].lo, obs_q[0].hi, obs_q[0].layer, obs_q[0].last} !== {mem[0], mem[1], LW'(0), 1'b1})
                $display("FAIL rstmid_pair: got %h/%h/%0d/%b want %h/%h/0/1",
                         obs_q[0].lo, obs_q[0].hi, obs_q[0].layer, obs_q[0].last, mem[0], mem[1]);
            else passed++;
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        int r0;
        for (int k = 0; k <= LM; k++) mem[k] = SW'({$urandom(), $urandom()});
        pr_mode = 0;
        obs_q.delete();
        r0 = req_count;
        @(posedge clk); #1;
        start_layers = 4'd3;
        start_valid  = 1'b1;
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            start_layers = LW'($urandom_range(1, LM));
            if (pair_valid && pair_last) start_valid = 1'b0;
            if (!busy) begin ok = 1; break; end
        end
        start_valid = 1'b0;
        checks++; if (!ok) $display("FAIL ignore_timeout: busy=%b want 0", busy); else passed++;
        checks++; if (obs_q.size() !== 3 || req_count - r0 !== 3)
            $display("FAIL ignore_count: got pairs=%0d reqs=%0d want 3/3", obs_q.size(), req_count - r0);
        else passed++;
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            checks++;
            if ({obs_q[i].layer, obs_q[i].last} !== {LW'(2 - i), 1'(i == 2)})
                $display("FAIL ignore_layer%0d: got %0d/%b want %0d/%b", i, obs_q[i].layer, obs_q[i].last, 2 - i, i == 2);
            else passed++;
        end
    endtask

    task automatic test_random();
        bit ok;
        int L, sb, hb;
        pair_t e;
        cfg_rand_addr_rdy = 1; cfg_stray = 1; pr_mode = 1;
        cfg_lo_dly = -1; cfg_hi_dly = -1;
        sb = stab_bad; hb = hold_bad;
        for (int pass = 0; pass < 8; pass++) begin
            for (int k = 0; k <= LM; k++) mem[k] = SW'({$urandom(), $urandom()});
            L = int'($urandom_range(1, LM));
            obs_q.delete();
            start_pass(LW'(L));
            wait_idle(ok);
            checks++; if (!ok || obs_q.size() !== L)
                $display("FAIL rand%0d_count: got %0d want %0d", pass, obs_q.size(), L);
            else passed++;
            for (int i = 0; i < L && i < obs_q.size(); i++) begin
                e = exp_pair(L, i);
                checks++;
                if ({obs_q[i].lo, obs_q[i].hi, obs_q[i].layer, obs_q[i].last} !== {e.lo, e.hi, e.layer, e.last})
                    $display("FAIL rand%0d_pair%0d: got %h/%h/%0d/%b want %h/%h/%0d/%b", pass, i,
                             obs_q[i].lo, obs_q[i].hi, obs_q[i].layer, obs_q[i].last, e.lo, e.hi, e.layer, e.last);
                else passed++;
            end
        end
        checks++; if (stab_bad - sb !== 0 || hold_bad - hb !== 0)
            $display("FAIL rand_stability: got stab=%0d hold=%0d want 0/0", stab_bad - sb, hold_bad - hb);
        else passed++;
        cfg_rand_addr_rdy = 0; cfg_stray = 0; pr_mode = 0;
    endtask

    initial begin
        rst          = 1'b1;
        start_layers = '0;
        start_valid  = 1'b0;
        for (int k = 0; k <= LM; k++) mem[k] = '0;
        test_reset();
        test_basic();
        test_order();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
